// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable fractional baud-rate generator for the UART.
// It divides clk by D + F/2^FRAC_W to make an oversample strobe, then by
// OVERSAMPLE to make a one-cycle baud strobe and a 50 % duty baud clock.
// The fractional part is spread over time by stretching some oversample
// periods by one cycle, chosen by the carry out of a phase accumulator.
module uart_baud_gen #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RESET_DIV  = 27,
  parameter int RESET_FRAC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              baud_clk,
  output logic              div_err
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_MID_PRE = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  div_q;
  logic [FRAC_W-1:0] frac_q;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [OS_W-1:0]   os_cnt;

  logic [DIV_W:0]    term_val;
  logic              terminal;
  logic              div_ok;
  logic [FRAC_W:0]   acc_sum;

  // Terminal count, fractional sum and divisor validity for this cycle.
  // The compare is one bit wider than the counter so that div_q - 1 + extra
  // cannot wrap when div_q is at its maximum and the period is stretched.
  always_comb begin
    term_val = {1'b0, div_q} - (DIV_W + 1)'(1) + {{DIV_W{1'b0}}, extra};
    terminal = ({1'b0, cnt} == term_val);
    div_ok   = (div_int >= DIV_W'(2));
    acc_sum  = {1'b0, acc} + {1'b0, frac_q};
  end

  // Divisor register, period counter, accumulator and registered strobes.
  // NOTE: every register here is state updated with non-blocking assignments,
  // so all comparisons above see the values from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= DIV_W'(RESET_DIV);
      frac_q    <= FRAC_W'(RESET_FRAC);
      cnt       <= '0;
      acc       <= '0;
      extra     <= 1'b0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      baud_clk  <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      div_err   <= 1'b0;
      if (div_wr && div_ok) begin
        // An accepted write restarts the whole chain; a coincident wrap is lost.
        div_q    <= div_int;
        frac_q   <= div_frac;
        cnt      <= '0;
        acc      <= '0;
        extra    <= 1'b0;
        os_cnt   <= '0;
        baud_clk <= 1'b0;
      end else begin
        if (div_wr) begin
          div_err <= 1'b1;
        end
        if (en) begin
          if (terminal) begin
            cnt     <= '0;
            acc     <= acc_sum[FRAC_W-1:0];
            extra   <= acc_sum[FRAC_W];
            os_tick <= 1'b1;
            os_cnt  <= os_cnt + OS_W'(1);
            if (os_cnt == OS_MID_PRE) begin
              baud_clk <= 1'b1;
            end
            if (os_cnt == OS_LAST) begin
              baud_clk  <= 1'b0;
              baud_tick <= 1'b1;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule
